// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and the conv1 clamp helper for the conv engine.
package conv_pkg;

  localparam int K_H       = 3;
  localparam int K_W       = 3;
  localparam int TAPS      = K_H * K_W;
  localparam int DEF_IN1_H = 16;
  localparam int DEF_IN1_W = 15;
  localparam int DEF_CHAN  = 10;
  localparam int ACC1_W    = 20;
  localparam int ACC2_W    = 24;
  localparam int CLAMP_MAX = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV1 = 2'd1,
    CONV2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Saturate a conv1 sum into 0..CLAMP_MAX; bits above bit 6 flag an overflow of 127.
  function automatic logic [7:0] clamp_conv1(input logic signed [ACC1_W-1:0] v);
    logic [7:0] res;
    if (v[ACC1_W-1]) begin
      res = 8'd0;
    end else if (|v[ACC1_W-2:7]) begin
      res = 8'(CLAMP_MAX);
    end else begin
      res = {1'b0, v[6:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_mac9.sv
// Combinational 9-tap signed dot product: 9-bit signed data times 8-bit signed weights.
module conv_mac9 #(
  parameter int ACC_W = 20
) (
  input  logic signed [8:0]       data   [9],
  input  logic signed [7:0]       weight [9],
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] dx;
  logic signed [ACC_W-1:0] wx;

  // Operands are widened to the accumulator width before multiplying so nothing overflows.
  always_comb begin
    acc = '0;
    dx  = '0;
    wx  = '0;
    for (int i = 0; i < 9; i++) begin
      dx  = {{(ACC_W-9){data[i][8]}}, data[i]};
      wx  = {{(ACC_W-8){weight[i][7]}}, weight[i]};
      acc = acc + dx * wx;
    end
  end

endmodule

// File: rtl/conv.sv
// Two-stage per-channel 3x3 convolution engine (conv1 -> clamp 0..127 -> conv2).
// Optional macro CONV_BUSY_EN adds a registered busy output.
module conv
  import conv_pkg::*;
#(
  parameter  int IN1_H  = DEF_IN1_H,
  parameter  int IN1_W  = DEF_IN1_W,
  parameter  int CHAN   = DEF_CHAN,
  localparam int OUT1_H = IN1_H - K_H + 1,
  localparam int OUT1_W = IN1_W - K_W + 1,
  localparam int OUT2_H = OUT1_H - K_H + 1,
  localparam int OUT2_W = OUT1_W - K_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trigger,
  input  logic        [7:0]  in_img   [IN1_H][IN1_W],
  input  logic signed [7:0]  w_conv1  [K_H][K_W][CHAN],
  input  logic signed [7:0]  w_conv2  [K_H][K_W][CHAN],
  output logic signed [23:0] out_buff [OUT2_H][OUT2_W],
  output logic               out_valid,
  output logic        [3:0]  out_chan
`ifdef CONV_BUSY_EN
  ,
  output logic               busy
`endif
);

  localparam int IY_W = $clog2(IN1_H);
  localparam int IX_W = $clog2(IN1_W);
  localparam int BY_W = $clog2(OUT1_H);
  localparam int BX_W = $clog2(OUT1_W);
  localparam int OY_W = $clog2(OUT2_H);
  localparam int OX_W = $clog2(OUT2_W);
  localparam int CH_W = (CHAN > 1) ? $clog2(CHAN) : 1;

  state_t state;
  state_t state_next;

  logic              trigger_q;
  logic              start;
  logic [3:0]        ch;
  logic [BY_W-1:0]   r;
  logic [BX_W-1:0]   c;
  logic [BY_W-1:0]   rb;
  logic [BX_W-1:0]   cb;
  logic              row_end1;
  logic              row_end2;
  logic              last1;
  logic              last2;
  logic              last_ch;
  logic [7:0]        buf1 [OUT1_H][OUT1_W];

  logic signed [8:0]        tap_img [9];
  logic signed [7:0]        tap_w1  [9];
  logic signed [8:0]        tap_buf [9];
  logic signed [7:0]        tap_w2  [9];
  logic signed [ACC1_W-1:0] acc1;
  logic signed [ACC2_W-1:0] acc2;

  assign start    = trigger & ~trigger_q & (state == IDLE);
  assign row_end1 = (c == BX_W'(OUT1_W - 1));
  assign row_end2 = (c == BX_W'(OUT2_W - 1));
  assign last1    = row_end1 && (r == BY_W'(OUT1_H - 1));
  assign last2    = row_end2 && (r == BY_W'(OUT2_H - 1));
  assign last_ch  = (ch == 4'(CHAN - 1));

  // Window taps; the conv1 buffer window is parked at origin outside CONV2 to stay in range.
  always_comb begin
    rb = (state == CONV2) ? r : '0;
    cb = (state == CONV2) ? c : '0;
    for (int ky = 0; ky < K_H; ky++) begin
      for (int kx = 0; kx < K_W; kx++) begin
        tap_img[ky*K_W+kx] = {1'b0, in_img[IY_W'(r) + IY_W'(ky)][IX_W'(c) + IX_W'(kx)]};
        tap_w1[ky*K_W+kx]  = w_conv1[ky][kx][CH_W'(ch)];
        tap_buf[ky*K_W+kx] = {1'b0, buf1[rb + BY_W'(ky)][cb + BX_W'(kx)]};
        tap_w2[ky*K_W+kx]  = w_conv2[ky][kx][CH_W'(ch)];
      end
    end
  end

  conv_mac9 #(.ACC_W(ACC1_W)) u_mac1 (
    .data   (tap_img),
    .weight (tap_w1),
    .acc    (acc1)
  );

  conv_mac9 #(.ACC_W(ACC2_W)) u_mac2 (
    .data   (tap_buf),
    .weight (tap_w2),
    .acc    (acc2)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = CONV1;
        else       state_next = IDLE;
      end
      CONV1: begin
        if (last1) state_next = CONV2;
        else       state_next = CONV1;
      end
      CONV2: begin
        if (last2) state_next = DONE;
        else       state_next = CONV2;
      end
      DONE: begin
        if (last_ch) state_next = IDLE;
        else         state_next = CONV1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: raster counters, conv1 buffer, result map, channel and valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trigger_q <= 1'b0;
      ch        <= 4'd0;
      r         <= '0;
      c         <= '0;
      out_valid <= 1'b0;
      out_chan  <= 4'd0;
      for (int y = 0; y < OUT1_H; y++)
        for (int x = 0; x < OUT1_W; x++)
          buf1[y][x] <= 8'd0;
      for (int y = 0; y < OUT2_H; y++)
        for (int x = 0; x < OUT2_W; x++)
          out_buff[y][x] <= 24'sd0;
    end else begin
      trigger_q <= trigger;
      out_valid <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            ch       <= 4'd0;
            out_chan <= 4'd0;
            r        <= '0;
            c        <= '0;
          end
        end
        CONV1: begin
          buf1[r][c] <= clamp_conv1(acc1);
          if (row_end1) begin
            c <= '0;
            r <= last1 ? '0 : r + BY_W'(1);
          end else begin
            c <= c + BX_W'(1);
          end
        end
        CONV2: begin
          out_buff[OY_W'(r)][OX_W'(c)] <= acc2;
          if (row_end2) begin
            c <= '0;
            r <= last2 ? '0 : r + BY_W'(1);
          end else begin
            c <= c + BX_W'(1);
          end
        end
        DONE: begin
          if (!last_ch) begin
            ch       <= ch + 4'd1;
            out_chan <= ch + 4'd1;
          end
        end
        default: begin
          ch <= 4'd0;
        end
      endcase
    end
  end

`ifdef CONV_BUSY_EN
  // Busy mirrors any non-IDLE state, aligned with the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
    end
  end
`endif

endmodule

// File: tb/tb_conv.sv
// Randomized scoreboard bench for conv: a reference model pushes expected maps, a monitor checks each out_valid.
module tb_conv;

  localparam int NCH = 4;
  localparam int H1 = 16, W1 = 15, H2 = 12, W2 = 11;
  localparam int PERIOD_CYC = 315;

  logic clk = 1'b0;
  logic rst_n;
  logic trigger;
  logic        [7:0]  img  [H1][W1];
  logic signed [7:0]  w1   [3][3][NCH];
  logic signed [7:0]  w2   [3][3][NCH];
  logic signed [23:0] out_buff [H2][W2];
  logic               out_valid;
  logic        [3:0]  out_chan;
`ifdef CONV_BUSY_EN
  logic               busy;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int trig_cyc = 0;
  int run_id = 0;
  int valid_cnt = 0;
  int exp_ch_q[$];
  int exp_px_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv #(.IN1_H(H1), .IN1_W(W1), .CHAN(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trigger   (trigger),
    .in_img    (img),
    .w_conv1   (w1),
    .w_conv2   (w2),
    .out_buff  (out_buff),
    .out_valid (out_valid),
    .out_chan  (out_chan)
`ifdef CONV_BUSY_EN
    ,
    .busy      (busy)
`endif
  );

  // Reference: plain integer convolution, clamp, convolution, wrap to signed 24 bits.
  task automatic push_model(input int nch);
    int a1 [14][13];
    int s;
    logic signed [23:0] t;
    for (int ch = 0; ch < nch; ch++) begin
      for (int y = 0; y < 14; y++)
        for (int x = 0; x < 13; x++) begin
          s = 0;
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              s += int'(img[y+ky][x+kx]) * int'(w1[ky][kx][ch]);
          a1[y][x] = (s < 0) ? 0 : ((s > 127) ? 127 : s);
        end
      exp_ch_q.push_back(ch);
      for (int y = 0; y < H2; y++)
        for (int x = 0; x < W2; x++) begin
          s = 0;
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              s += a1[y+ky][x+kx] * int'(w2[ky][kx][ch]);
          t = s[23:0];
          exp_px_q.push_back(int'(t));
        end
    end
  endtask

  // Monitor: pops expected maps on every out_valid and checks timing between pulses.
  initial begin
    int mon_run = 0;
    int last_cyc = 0;
    int ech, e, a, nbad, br, bc, ba, be;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        valid_cnt++;
        checks++;
        if (mon_run != run_id) begin
          if (cyc - trig_cyc < PERIOD_CYC - 1 || cyc - trig_cyc > PERIOD_CYC + 1) begin
            errors++;
            $display("FAIL first_latency: got %0d cycles, want %0d..%0d", cyc - trig_cyc, PERIOD_CYC - 1, PERIOD_CYC + 1);
          end
          mon_run = run_id;
        end else if (cyc - last_cyc != PERIOD_CYC) begin
          errors++;
          $display("FAIL valid_spacing: got %0d cycles, want %0d", cyc - last_cyc, PERIOD_CYC);
        end
        last_cyc = cyc;
        checks++;
        if (exp_ch_q.size() == 0 || exp_px_q.size() < H2 * W2) begin
          errors++;
          $display("FAIL unexpected_valid: out_valid=1 chan=%0d, want no pulse", out_chan);
        end else begin
          ech = exp_ch_q.pop_front();
          if (int'(out_chan) != ech) begin
            errors++;
            $display("FAIL out_chan: got %0d, want %0d", out_chan, ech);
          end
          checks++;
          nbad = 0; br = 0; bc = 0; ba = 0; be = 0;
          for (int y = 0; y < H2; y++)
            for (int x = 0; x < W2; x++) begin
              e = exp_px_q.pop_front();
              a = int'(out_buff[y][x]);
              if (a != e) begin
                if (nbad == 0) begin br = y; bc = x; ba = a; be = e; end
                nbad++;
              end
            end
          if (nbad != 0) begin
            errors++;
            $display("FAIL out_buff ch%0d: %0d bad pixels, first (%0d,%0d) got %0d want %0d", ech, nbad, br, bc, ba, be);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_cleared(input string name);
    int nz = 0;
    for (int y = 0; y < H2; y++)
      for (int x = 0; x < W2; x++)
        if (out_buff[y][x] != 24'sd0) nz++;
    check({name, "_valid"}, int'(out_valid), 0);
    check({name, "_chan"}, int'(out_chan), 0);
    check({name, "_buff_nonzero"}, nz, 0);
  endtask

  task automatic pulse_trigger(input bit new_run);
    @(negedge clk);
    if (new_run) begin
      run_id++;
      trig_cyc = cyc;
    end
    trigger = 1'b1;
    repeat (2) @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_valids(input string name, input int target, input int budget);
    for (int i = 0; i < budget && valid_cnt < target; i++) @(negedge clk);
    @(negedge clk);
    check({name, "_completed"}, valid_cnt, target);
  endtask

  task automatic run_and_check(input string name, input int mid_retrigger);
    int base;
    push_model(NCH);
    base = valid_cnt;
    pulse_trigger(1'b1);
    if (mid_retrigger != 0) begin
      repeat (PERIOD_CYC + 182 + 30) @(negedge clk);
      pulse_trigger(1'b0);
    end
    wait_valids(name, base + NCH, NCH * 10000);
    repeat (400) @(negedge clk);
    check({name, "_total_pulses"}, valid_cnt - base, NCH);
    check({name, "_queue_drained"}, exp_ch_q.size(), 0);
  endtask

  task automatic fill(input int img_mode, input int w1_mode, input int w2_mode);
    for (int y = 0; y < H1; y++)
      for (int x = 0; x < W1; x++)
        img[y][x] = (img_mode == 0) ? 8'd1 : (img_mode == 1) ? 8'd255 : 8'($urandom_range(0, 255));
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        for (int ch = 0; ch < NCH; ch++) begin
          case (w1_mode)
            0:       w1[ky][kx][ch] = 8'sd1;
            1:       w1[ky][kx][ch] = -8'sd1;
            2:       w1[ky][kx][ch] = 8'($urandom_range(0, 255));
            default: w1[ky][kx][ch] = 8'(int'($urandom_range(0, 8)) - 4);
          endcase
          case (w2_mode)
            0:       w2[ky][kx][ch] = 8'sd1;
            1:       w2[ky][kx][ch] = -8'sd128;
            default: w2[ky][kx][ch] = 8'($urandom_range(0, 255));
          endcase
        end
  endtask

  initial begin
    int seed_val, base;
    seed_val = $urandom(32'hDEADBEEF);
    rst_n = 1'b0;
    trigger = 1'b0;
    fill(0, 0, 0);
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill(0, 0, 0);  run_and_check("ones", 0);
    fill(1, 0, 1);  run_and_check("sat_neg", 0);
    fill(2, 1, 2);  run_and_check("clamp_zero", 0);
    fill(2, 2, 2);  run_and_check("random_full", 0);
    fill(2, 3, 2);  run_and_check("random_small", 0);
    fill(2, 3, 2);  run_and_check("retrigger_mid", 1);

    // Reset in CONV1 of channel 2: only channels 0 and 1 may report.
    fill(2, 3, 2);
    push_model(2);
    base = valid_cnt;
    pulse_trigger(1'b1);
    wait_valids("pre_reset", base + 2, 2 * 10000);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_cleared("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    check("no_pulse_after_reset", valid_cnt - base, 2);
    run_and_check("restart", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
